// File: rtl/apb_slave_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : apb_slave_responder_pkg
// Brief    : Shared APB constants, FSM state type and sizing helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package apb_slave_responder_pkg;

  localparam int ADDRESS_WIDTH      = 32;
  localparam int DATA_WIDTH         = 64;
  localparam int MIN_ADDR_RANGE     = 0;
  localparam int MAX_ADDR_RANGE     = 32;
  localparam int APB_WAIT_CFG_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } operation_states_e;

  function automatic int words_in_range(input int lo, input int hi, input int dw);
    return (hi - lo) / (dw / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem.sv
//------------------------------------------------------------------------------
// Module   : apb_slave_mem
// Brief    : Byte-strobed register file, combinational read, sync clear.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_slave_mem
  import apb_slave_responder_pkg::*;
#(
  parameter int WORD_WIDTH = DATA_WIDTH,
  parameter int NUM_WORDS  = words_in_range(MIN_ADDR_RANGE, MAX_ADDR_RANGE, DATA_WIDTH),
  parameter int IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [IDX_WIDTH-1:0]    i_widx,
  input  logic [WORD_WIDTH-1:0]   i_wdata,
  input  logic [WORD_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_WIDTH-1:0]    i_ridx,
  output logic [WORD_WIDTH-1:0]   o_rdata
);

  logic [WORD_WIDTH-1:0] r_mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        r_mem[w] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < WORD_WIDTH / 8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/apb_slave_responder.sv
//------------------------------------------------------------------------------
// Module   : apb_slave_responder
// Brief    : APB4 completer with programmable wait states and error decode.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_slave_responder #(
  parameter int ADDRESS_WIDTH  = apb_slave_responder_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = apb_slave_responder_pkg::DATA_WIDTH,
  parameter int MIN_ADDR_RANGE = apb_slave_responder_pkg::MIN_ADDR_RANGE,
  parameter int MAX_ADDR_RANGE = apb_slave_responder_pkg::MAX_ADDR_RANGE,
  parameter int PROT_CHECK     = 0
) (
  input  logic                                                  pclk,
  input  logic                                                  preset_n,
  input  logic                                                  pselx,
  input  logic                                                  penable,
  input  logic                                                  pwrite,
  input  logic [ADDRESS_WIDTH-1:0]                              paddr,
  input  logic [DATA_WIDTH-1:0]                                 pwdata,
  input  logic [DATA_WIDTH/8-1:0]                               pstrb,
  input  logic [2:0]                                            pprot,
  input  logic [apb_slave_responder_pkg::APB_WAIT_CFG_WIDTH-1:0] wait_cfg,
  output logic                                                  pready,
  output logic [DATA_WIDTH-1:0]                                 prdata,
  output logic                                                  pslverr
);

  import apb_slave_responder_pkg::*;

  localparam int c_LANES     = DATA_WIDTH / 8;
  localparam int c_LSB       = $clog2(c_LANES);
  localparam int c_NUM_WORDS = words_in_range(MIN_ADDR_RANGE, MAX_ADDR_RANGE, DATA_WIDTH);
  localparam int c_IDX_W     = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;

  localparam logic [1:0] c_S_IDLE   = IDLE;
  localparam logic [1:0] c_S_ACCESS = ACCESS;

  logic [1:0]                    r_state;
  logic [APB_WAIT_CFG_WIDTH-1:0] r_cnt;
  logic                          r_write;
  logic                          r_err;
  logic [c_IDX_W-1:0]            r_idx;
  logic [DATA_WIDTH-1:0]         r_wdata;
  logic [c_LANES-1:0]            r_strb;

  logic                     w_setup;
  logic                     w_below;
  logic                     w_above;
  logic                     w_prot_err;
  logic                     w_err;
  logic [ADDRESS_WIDTH-1:0] w_off;
  logic [c_IDX_W-1:0]       w_idx;
  logic [c_IDX_W-1:0]       w_ridx;
  logic [DATA_WIDTH-1:0]    w_mem_rdata;
  logic [DATA_WIDTH-1:0]    w_load_rdata;
  logic                     w_complete;
  logic                     w_we;
  logic                     w_unused;

  assign w_setup    = (r_state == c_S_IDLE) & pselx & ~penable;
  assign w_below    = $signed({1'b0, paddr}) < $signed({1'b0, ADDRESS_WIDTH'(MIN_ADDR_RANGE)});
  assign w_above    = $signed({1'b0, paddr}) >= $signed({1'b0, ADDRESS_WIDTH'(MAX_ADDR_RANGE)});
  assign w_prot_err = (PROT_CHECK != 0) && pwrite && !pprot[0];
  assign w_err      = w_below | w_above | (paddr[c_LSB-1:0] != '0) | w_prot_err;
  assign w_off      = paddr - ADDRESS_WIDTH'(MIN_ADDR_RANGE);
  assign w_idx      = w_off[c_LSB +: c_IDX_W];

  // Zero-wait reads fetch with the live address at the setup edge.
  assign w_ridx       = w_setup ? w_idx : r_idx;
  assign w_load_rdata = w_setup ? ((!pwrite && !w_err) ? w_mem_rdata : '0)
                                : ((!r_write && !r_err) ? w_mem_rdata : '0);

  assign w_complete = (r_state == c_S_ACCESS) & pselx & penable & pready;
  assign w_we       = w_complete & r_write & ~r_err;
  assign w_unused   = ^{pprot[2:1], w_off};

  apb_slave_mem #(
    .WORD_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (c_NUM_WORDS),
    .IDX_WIDTH  (c_IDX_W)
  ) u_mem (
    .clk     (pclk),
    .rst_n   (preset_n),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_ridx  (w_ridx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state <= c_S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_setup) begin
            r_state <= c_S_ACCESS;
            r_cnt   <= wait_cfg;
            r_write <= pwrite;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
            if (wait_cfg == '0) begin
              pready  <= 1'b1;
              pslverr <= w_err;
              prdata  <= w_load_rdata;
            end
          end
        end
        c_S_ACCESS: begin
          if (!pselx || w_complete) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else if (!pready) begin
            if (r_cnt <= APB_WAIT_CFG_WIDTH'(1)) begin
              r_cnt   <= '0;
              pready  <= 1'b1;
              pslverr <= r_err;
              prdata  <= w_load_rdata;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/apb_slave_responder.md
# apb_slave_responder

APB4 completer: synthesizable responder at the far end of the APB bus driven by the master agent. Samples the setup phase, inserts a programmable number of wait states, and services reads and writes against a small byte-strobed register file. Flags out-of-range, misaligned and (optionally) unprivileged writes with `pslverr`. Serves as the DUT-side slave model the slave agent monitors; one instance per `pselx` line, up to `NO_OF_SLAVES`.

## Interface
- `ADDRESS_WIDTH`, 32, width of `paddr`.
- `DATA_WIDTH`, 64, width of `pwdata`/`prdata`; `pstrb` width is `DATA_WIDTH/8`.
- `MIN_ADDR_RANGE`, 0, lowest valid byte address, inclusive.
- `MAX_ADDR_RANGE`, 32, valid byte addresses are below this; 32 with 64-bit data gives 4 words.
- `PROT_CHECK`, 0, when 1 a write with `pprot[0]=0` errors.
- `pclk` in 1: bus clock; all logic on rising edge.
- `preset_n` in 1: reset, synchronous, active-low.
- `pselx` in 1: this slave is selected.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 write, 0 read.
- `paddr` in ADDRESS_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in DATA_WIDTH/8: write byte lanes.
- `pprot` in 3: protection attributes.
- `wait_cfg` in 4: wait states per transfer, sampled in setup.
- `pready` out 1: transfer completes this cycle; registered.
- `prdata` out DATA_WIDTH: read data, valid with `pready` on reads; registered.
- `pslverr` out 1: error, valid with `pready`; registered.

## Operation
- FSM state type is `operation_states_e`; register holds IDLE or ACCESS. SETUP is the decoded condition `pselx & !penable` while in IDLE and is never held.
- IDLE: on SETUP, latch `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot` and `wait_cfg` into the counter, evaluate error, then go to ACCESS.
- Error when any of:
  - address < MIN_ADDR_RANGE or ≥ MAX_ADDR_RANGE;
  - `paddr[log2(DATA_WIDTH/8)-1:0] != 0`;
  - `PROT_CHECK` && write && `pprot[0]==0`.
- ACCESS: `pready` rises after exactly `wait_cfg` access cycles. Completion is the edge where `pselx & penable & pready`:
  - write without error: lanes with `pstrb[i]=1` are updated; other lanes are kept.
  - read: `prdata` was loaded with the word when `pready` was set, or 0 on error.
  - then `pready`, `pslverr` and `prdata` go to 0 and the FSM returns to IDLE.
- Abort: `pselx` low in ACCESS before completion returns to IDLE with no write and `pready` kept 0.
- `penable` high while IDLE is ignored.
- `pstrb` is ignored on reads.
- Error writes never modify storage.

## Timing
- Reset (sampled `preset_n=0`): state IDLE; `pready`, `pslverr` and `prdata` all 0; counter 0; all storage words 0. Reset takes effect mid-transfer; the pending write is dropped.
- Cycle T0 is the setup cycle. With `wait_cfg=0`, `pready=1` in T1, the first access cycle, giving zero wait states.
- With `wait_cfg=N`, `pready=1` in T(N+1).
- Counter rule:
  - loaded with N at the T0 edge;
  - decrements each ACCESS edge while `pready=0`;
  - `pready` is set on the edge where counter==1, or at the T0 edge if N==0.
- Write data is visible to a read whose setup phase is the cycle after completion (back-to-back, no idle cycle required).
- Consecutive transfers: minimum 2 cycles each, setup plus access.

## Structure
- Reuse from the shared global package: `operation_states_e`, `ADDRESS_WIDTH`, `DATA_WIDTH`, `MIN_ADDR_RANGE`, `MAX_ADDR_RANGE`.
- Add to the shared global package: `APB_WAIT_CFG_WIDTH = 4`.
- Sub-module `apb_slave_mem`: holds `(MAX_ADDR_RANGE-MIN_ADDR_RANGE)/(DATA_WIDTH/8)` words.
  - write port with byte enables;
  - combinational read;
  - synchronous clear on reset.
- FSM, error decode and counter live in the top.

## Test plan
- Write 0x1122334455667788 to 0x08, `pstrb`=0xFF, `wait_cfg`=0; then read 0x08 → `pready` in T1 both times, `prdata`=0x1122334455667788, `pslverr`=0.
- Write 0xFFFFFFFFFFFFFFFF to 0x10 with `pstrb`=0x0F over a cleared word, then read 0x10 → 0x00000000FFFFFFFF.
- `wait_cfg`=3, read 0x00 → `pready` low for access cycles 1–3 and high in cycle 4; `prdata`=0 after reset.
- Write to 0x20 (out of range) and to 0x0C (misaligned) → `pslverr`=1 with `pready`; a following read of 0x08 shows it unchanged.
- `wait_cfg`=5, write 0xAA to 0x18, drop `pselx` after 2 access cycles → no `pready`; read 0x18 returns 0.
- `PROT_CHECK`=1: write with `pprot`=3'b000 → `pslverr`=1, storage unchanged; with `pprot`=3'b001 → succeeds.
- `preset_n` low during ACCESS of a write with `wait_cfg`=4 → next cycle all outputs 0 and state IDLE; readback of that address gives 0.
